// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM encodings, oversampling defaults and the
// mid-bit tick derivation, common to the receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

    localparam int OVERSAMPLE_DEF = 16;

    // XOR over data bits plus parity bit that a correct even-parity frame yields
    localparam logic PARITY_EVEN = 1'b0;

    // Tick count at which the start bit is re-checked, landing later samples mid-bit
    function automatic int mid_tick(input int oversample);
        return oversample / 2 - 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, LSB-first deserialisation,
// optional even parity and stop-bit check, with one-cycle result strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int PARITY_EN  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_tick,
    input  logic             rx,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             framing_err,
    output logic             busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [TW-1:0] MID_T    = TW'(mid_tick(OVERSAMPLE));
    localparam logic [TW-1:0] LAST_T   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    uart_state_e      state, state_n;
    logic [TW-1:0]    tick_cnt, tick_n;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [WIDTH-1:0] shift, shift_n, dout_n;
    logic             perr, perr_n;
    logic             valid_n, perr_stb_n, ferr_n;
    logic             rx_s;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            perr        <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            state       <= state_n;
            tick_cnt    <= tick_n;
            bit_cnt     <= bit_n;
            shift       <= shift_n;
            perr        <= perr_n;
            data_out    <= dout_n;
            data_valid  <= valid_n;
            parity_err  <= perr_stb_n;
            framing_err <= ferr_n;
        end
    end

    always_comb begin
        state_n    = state;
        tick_n     = tick_cnt;
        bit_n      = bit_cnt;
        shift_n    = shift;
        perr_n     = perr;
        dout_n     = data_out;
        valid_n    = 1'b0;
        perr_stb_n = 1'b0;
        ferr_n     = 1'b0;
        if (sample_tick) begin
            tick_n = (tick_cnt == LAST_T) ? '0 : tick_cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    tick_n = '0;
                    if (!rx_s) state_n = START;
                end
                START: begin
                    if (tick_cnt == MID_T) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        perr_n  = 1'b0;
                        state_n = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick_cnt == LAST_T) begin
                        shift_n = {rx_s, shift[WIDTH-1:1]};
                        bit_n   = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT)
                            state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (tick_cnt == LAST_T) begin
                        perr_n  = ((^shift) ^ rx_s) != PARITY_EVEN;
                        state_n = STOP;
                    end
                end
                STOP: begin
                    if (tick_cnt == LAST_T) begin
                        // A low stop bit outranks any parity result
                        if (!rx_s) begin
                            ferr_n  = 1'b1;
                            state_n = BREAK;
                        end else if (perr) begin
                            perr_stb_n = 1'b1;
                            state_n    = IDLE;
                        end else begin
                            dout_n  = shift;
                            valid_n = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end
                BREAK: begin
                    tick_n = '0;
                    if (rx_s) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: one instance without parity, one with even parity.
module tb_uart_rx;

    localparam int OS = 16;
    localparam int W  = 8;

    typedef struct {
        int         tick;
        int         kind;   // 0 data_valid, 1 parity_err, 2 framing_err
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_tick = 1'b0;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic [7:0] dout0, dout1;
    logic       dv0, dv1, pe0, pe1, fe0, fe1, busy0, busy1;

    int   errors = 0, checks = 0;
    int   tick_num = 0, div = 0;
    bit   just_ticked = 1'b0;
    exp_t q0[$], q1[$];
    logic [7:0] last_good[2];
    int   dv_cnt[2], pe_cnt[2], fe_cnt[2];

    uart_rx #(.WIDTH(W), .OVERSAMPLE(OS), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx(rx0),
        .data_out(dout0), .data_valid(dv0), .parity_err(pe0),
        .framing_err(fe0), .busy(busy0)
    );

    uart_rx #(.WIDTH(W), .OVERSAMPLE(OS), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx(rx1),
        .data_out(dout1), .data_valid(dv1), .parity_err(pe1),
        .framing_err(fe1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // sample_tick: one clk in every four
    initial forever begin
        @(negedge clk);
        div = (div + 1) % 4;
        sample_tick = (div == 0);
    end

    initial forever begin
        @(posedge clk);
        just_ticked = sample_tick;
        if (sample_tick) tick_num++;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp(input int id, input logic dv, input logic pe, input logic fe,
                       input logic [7:0] dout);
        exp_t e;
        logic [2:0] want;
        want = 3'b000;
        if (id == 0) begin
            if (q0.size() > 0 && just_ticked && q0[0].tick == tick_num) begin
                e = q0.pop_front();
                want = 3'b001 << e.kind;
            end
        end else begin
            if (q1.size() > 0 && just_ticked && q1[0].tick == tick_num) begin
                e = q1.pop_front();
                want = 3'b001 << e.kind;
            end
        end
        if (want == 3'b001) last_good[id] = e.data;
        if (dv) dv_cnt[id]++;
        if (pe) pe_cnt[id]++;
        if (fe) fe_cnt[id]++;
        chk($sformatf("dut%0d strobes{fe,pe,dv} tick %0d", id, tick_num), {fe, pe, dv}, want);
        chk($sformatf("dut%0d data_out tick %0d", id, tick_num), dout, last_good[id]);
    endtask

    initial forever begin
        @(negedge clk);
        if (rst) begin
            cmp(0, dv0, pe0, fe0, dout0);
            cmp(1, dv1, pe1, fe1, dout1);
        end
    end

    // Returns #1 after the n-th tick edge, so a new rx level is seen on the next tick
    task automatic tick_wait(input int n);
        repeat (n) begin
            do @(posedge clk); while (!sample_tick);
        end
        #1;
    endtask

    task automatic set_rx(input int id, input logic v);
        if (id == 0) rx0 = v; else rx1 = v;
    endtask

    // Result is decided at the centre of the stop bit
    task automatic send_frame(input int id, input logic [7:0] d, input bit wp,
                              input bit pb, input bit sb);
        exp_t e;
        e.tick = tick_num + 1 + OS * (1 + W + int'(wp)) + OS / 2;
        e.data = d;
        if (!sb) e.kind = 2;
        else if (wp && ((^d) ^ pb)) e.kind = 1;
        else e.kind = 0;
        if (id == 0) q0.push_back(e); else q1.push_back(e);
        set_rx(id, 1'b0);
        tick_wait(OS);
        for (int i = 0; i < W; i++) begin
            set_rx(id, d[i]);
            tick_wait(OS);
        end
        if (wp) begin
            set_rx(id, pb);
            tick_wait(OS);
        end
        set_rx(id, sb);
        tick_wait(OS);
    endtask

    initial begin
        logic [7:0] a5;
        last_good[0] = 8'h00; last_good[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            dv_cnt[i] = 0; pe_cnt[i] = 0; fe_cnt[i] = 0;
        end
        #2 rst = 1'b0;
        tick_wait(3);
        chk("reset busy0", busy0, 1'b0);
        chk("reset data_out0", dout0, 8'h00);
        chk("reset strobes0", {fe0, pe0, dv0}, 3'b000);
        chk("reset data_out1", dout1, 8'h00);
        rst = 1'b1;

        tick_wait(200);
        chk("idle busy0", busy0, 1'b0);
        chk("idle data_out0", dout0, 8'h00);
        chk("idle dv count", dv_cnt[0], 0);

        send_frame(0, 8'hAD, 1'b0, 1'b0, 1'b1);
        tick_wait(4);
        chk("AD data_out0", dout0, 8'hAD);
        chk("AD dv count", dv_cnt[0], 1);
        chk("AD err count", pe_cnt[0] + fe_cnt[0], 0);

        send_frame(1, 8'hAD, 1'b1, 1'b1, 1'b1);
        tick_wait(4);
        chk("par ok data_out1", dout1, 8'hAD);
        chk("par ok dv count", dv_cnt[1], 1);
        send_frame(1, 8'hAD, 1'b1, 1'b0, 1'b1);
        tick_wait(4);
        chk("par bad pe count", pe_cnt[1], 1);
        chk("par bad dv count", dv_cnt[1], 1);
        chk("par bad data_out1", dout1, 8'hAD);

        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("break busy0", busy0, 1'b1);
        tick_wait(50);
        chk("break held busy0", busy0, 1'b1);
        chk("framing fe count", fe_cnt[0], 1);
        chk("framing dv count", dv_cnt[0], 1);
        rx0 = 1'b1;
        tick_wait(3);
        chk("break exit busy0", busy0, 1'b0);
        tick_wait(5);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        tick_wait(4);
        chk("55 data_out0", dout0, 8'h55);
        chk("55 dv count", dv_cnt[0], 2);

        rx0 = 1'b0;
        tick_wait(4);
        rx0 = 1'b1;
        tick_wait(12);
        chk("glitch busy0", busy0, 1'b0);
        chk("glitch dv count", dv_cnt[0], 2);

        send_frame(0, 8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h80, 1'b0, 1'b0, 1'b1);
        tick_wait(4);
        chk("b2b data_out0", dout0, 8'h80);
        chk("b2b dv count", dv_cnt[0], 5);

        a5 = 8'hA5;
        rx0 = 1'b0;
        tick_wait(OS);
        for (int i = 0; i < 3; i++) begin
            rx0 = a5[i];
            tick_wait(OS);
        end
        rx0 = a5[3];
        tick_wait(5);
        chk("mid-frame busy0", busy0, 1'b1);
        rst = 1'b0;
        last_good[0] = 8'h00; last_good[1] = 8'h00;
        #1;
        chk("mid reset data_out0", dout0, 8'h00);
        chk("mid reset busy0", busy0, 1'b0);
        chk("mid reset data_out1", dout1, 8'h00);
        rx0 = 1'b1;
        tick_wait(10);
        rst = 1'b1;
        tick_wait(10);
        chk("post reset dv count", dv_cnt[0], 5);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        tick_wait(4);
        chk("5A data_out0", dout0, 8'h5A);
        chk("5A dv count", dv_cnt[0], 6);

        tick_wait(20);
        chk("dut0 pending expectations", q0.size(), 0);
        chk("dut1 pending expectations", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the transmitter's PISO/framing path.
- Samples serial line rx at OVERSAMPLE x baud (sample_tick comes from the shared baud generator).
- Detects the start bit and deserialises WIDTH data bits LSB-first, with optional even parity; checks the stop bit.
- Presents the word on a parallel output with a one-cycle valid strobe and error flags.

Parameters:
WIDTH, 8, data bits per frame
OVERSAMPLE, 16, sample_tick pulses per bit period (even, >= 4)
PARITY_EN, 0, 1 = one even-parity bit follows the data bits

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
sample_tick  input  1  one-clk pulse at OVERSAMPLE x baud
rx  input  1  serial line, idle high, asynchronous to clk
data_out  output  WIDTH  last good received word
data_valid  output  1  one-clk pulse: data_out updated
parity_err  output  1  one-clk pulse: parity mismatch, frame dropped
framing_err  output  1  one-clk pulse: stop bit sampled low, frame dropped
busy  output  1  high when state != IDLE

Behaviour:
- Reset (rst=0, async):
  - state IDLE; all counters 0; shift register 0.
  - data_out 0; data_valid, parity_err, framing_err and busy all 0.
  - Synchroniser flops reset to 1.
  - Reset mid-frame abandons the frame; no strobe is produced.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
- tick_cnt (log2 OVERSAMPLE bits) and bit_cnt (log2 WIDTH+1 bits) advance only on sample_tick.
- MID = OVERSAMPLE/2 - 1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. Transitions are evaluated on sample_tick only.
  - IDLE: rx_s == 0 -> START, tick_cnt = 0.
  - START: when tick_cnt == MID:
    - rx_s == 0 -> DATA, tick_cnt = 0, bit_cnt = 0.
    - rx_s == 1 -> IDLE (glitch rejected, no flag).
  - DATA: when tick_cnt == OVERSAMPLE-1:
    - Shift rx_s into the MSB (shift right); bit_cnt++.
    - After the WIDTH-th bit: -> PARITY if PARITY_EN, else -> STOP. tick_cnt wraps to 0.
    - Samples therefore land at mid-bit.
  - PARITY: when tick_cnt == OVERSAMPLE-1, latch perr = (^shift) ^ rx_s, then -> STOP.
  - STOP: when tick_cnt == OVERSAMPLE-1, sample rx_s:
    - rx_s == 1 and perr == 0: data_out <= shift, data_valid = 1 -> IDLE.
    - rx_s == 1 and perr == 1: parity_err = 1, data_out unchanged -> IDLE.
    - rx_s == 0: framing_err = 1 -> BREAK. Framing takes priority over parity; only one flag pulses.
  - BREAK: stay until rx_s == 1, then -> IDLE. Prevents a held-low line from re-triggering.
- Strobe timing: each strobe is registered and high for exactly one clk, on the cycle after the clk edge where the deciding sample_tick is seen. Strobes are mutually exclusive.
- Latency: end of rx start-bit falling edge to data_valid is 2 clk (sync) + (1 + WIDTH + PARITY_EN) x OVERSAMPLE ticks + MID ticks + 1 clk, ±1 tick of edge-detect jitter.
- A new start edge is accepted on the first sample_tick in IDLE. Back-to-back frames with no idle gap are received.
- rx changes between ticks are ignored; only the tick-aligned sample matters. No majority voting.
- data_out holds its value until the next good frame.

Decomposition:
- Shared uart package/header holds:
  - FSM state encodings (IDLE..BREAK), also usable by the transmitter.
  - OVERSAMPLE default.
  - The MID derivation.
  - Parity-mode constant.
- One sub-module: sync_2ff (2-flop synchroniser, reset value 1). It is reusable for other async inputs.
- The shift register stays inline. It is the SIPO mirror of the transmitter PISO and is too small to split out.

Test Plan:
- Reset then idle rx=1 for 200 ticks -> no strobes, busy 0, data_out 0x00.
- Frame 0xAD (line bits: start 0, 1,0,1,1,0,1,0,1, stop 1), PARITY_EN=0 -> exactly one data_valid pulse, data_out=0xAD, both error flags stay 0.
- PARITY_EN=1, send 0xAD with parity 1 -> data_valid, data_out=0xAD. Send 0xAD with parity 0 -> parity_err pulse only, data_out stays 0xAD from the prior frame.
- Stop bit forced 0 on 0x3C, then rx held low 50 ticks, then high -> single framing_err pulse, state BREAK until rx high, no data_valid, next frame 0x55 received correctly.
- rx low pulse of 4 ticks (< MID) -> returns to IDLE, no strobes. Then back-to-back frames 0x01, 0xFF, 0x80 with zero idle gap -> three data_valid pulses with those values in order.
- Assert rst low during bit 3 of frame 0xA5 -> outputs 0 immediately. Release, send 0x5A -> data_out=0x5A, no stale strobe.
